mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single block-wide main memory between the instruction cache (read-only, block refills) and the data cache (block refills and write-backs).
- Sits between the two cache controllers and the main-memory model, replacing each cache's private memory instance.
- Serves one block transaction at a time, non-preemptive.
- Fixed priority: the data cache wins over the instruction cache, because its request belongs to an older instruction in the pipeline.

Parameters:
- ADDR_W, 28, block address width (word address bits [31:4]).
- BLOCK_W, 128, block data width (4 words).

Ports:
- CLK  in  1  clock; all state updates on negedge, consistent with the cache FSMs.
- RESET  in  1  reset.
- I_READ  in  1  instruction-cache refill request, held until I_BUSYWAIT falls.
- I_ADDR  in  ADDR_W  instruction-cache block address.
- I_READDATA  out  BLOCK_W  block returned to the instruction cache.
- I_BUSYWAIT  out  1  instruction-cache stall.
- D_READ  in  1  data-cache refill request.
- D_WRITE  in  1  data-cache write-back request.
- D_ADDR  in  ADDR_W  data-cache block address.
- D_WRITEDATA  in  BLOCK_W  write-back block.
- D_READDATA  out  BLOCK_W  block returned to the data cache.
- D_BUSYWAIT  out  1  data-cache stall.
- MEM_READ  out  1  main-memory read strobe.
- MEM_WRITE  out  1  main-memory write strobe.
- MEM_ADDR  out  ADDR_W  main-memory block address.
- MEM_WRITEDATA  out  BLOCK_W  main-memory write data.
- MEM_READDATA  in  BLOCK_W  main-memory read data.
- MEM_BUSYWAIT  in  1  main-memory busy.

Reset RESET, asynchronous, active-high.

Behaviour:
- Memory contract:
  - MEM_BUSYWAIT is high, combinationally, in every cycle a strobe is asserted, except the final (completion) cycle.
  - MEM_READDATA is valid in the completion cycle.
- Requester contract: a cache holds its strobe, address and write data stable until its BUSYWAIT is low at a negedge. It drops the strobe in the next cycle.
- D_READ and D_WRITE high together is illegal; D_WRITE takes precedence.
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Encoding is in the package. Transitions occur at negedge.
  - IDLE: if D_READ|D_WRITE, go to GRANT_D; else if I_READ, go to GRANT_I; else stay.
  - GRANT_x: if MEM_BUSYWAIT=0 (completion), go to RELEASE; else stay.
  - RELEASE: one bubble cycle with no strobes, so memory sees the strobe drop; then go to IDLE.
- Outputs (all combinational from state and inputs):
  - MEM_READ/MEM_WRITE/MEM_ADDR/MEM_WRITEDATA are driven from the granted requester in GRANT_x only.
  - Strobes are 0 and buses are 0 in IDLE and RELEASE.
- I_BUSYWAIT = I_READ and not (state=GRANT_I and MEM_BUSYWAIT=0). D_BUSYWAIT is the same with D_READ|D_WRITE and GRANT_D.
  - Result: a waiting requester stays stalled through the other requester's whole grant and the RELEASE cycle.
- Read data:
  - data_q (BLOCK_W) captures MEM_READDATA at the negedge ending a completion cycle.
  - x_READDATA = MEM_READDATA in x's completion cycle; otherwise data_q.
  - Both outputs are driven from this same path.
  - Data stays stable until the next completion, covering the cache's CACHE_WRITE cycle.
  - A write completion also updates data_q; its content is don't-care.
- Latency: request seen in IDLE means the strobe reaches memory 1 cycle later. Minimum turnaround between back-to-back grants is 2 cycles (RELEASE + IDLE).
- Simultaneous requests in IDLE: D wins; I waits with I_BUSYWAIT=1. Without the optional feature, continuous D traffic can starve I; this is accepted.
- A request dropped while not granted (e.g. after a branch) is simply not served. Dropping a request during its own grant is illegal.
- Reset, including mid-transaction:
  - state goes to IDLE, data_q to 0, the last-grant register to D.
  - MEM strobes fall immediately (asynchronously).
  - BUSYWAITs follow the request inputs.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register is updated on each grant.
  - On simultaneous requests in IDLE, grant the requester not served last.
  - A lone request is granted as usual.
- Undefined: fixed D-over-I priority; no last_grant register.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_W/BLOCK_W defaults.
  - State encodings ST_IDLE=2'b00, ST_GRANT_I=2'b01, ST_GRANT_D=2'b10, ST_RELEASE=2'b11.
  - Grant-owner constants OWNER_I/OWNER_D.
- One sub-module: arb_pick, a combinational pick of the next owner from the two requests plus last_grant. This isolates the MEM_ARB_RR_EN logic.

Test Plan:
1. Lone I_READ, I_ADDR=28'h0000010, memory 3 busy cycles, MEM_READDATA=128'hA5A5…
   - MEM_READ=1 with MEM_ADDR=0x10 one cycle later.
   - I_BUSYWAIT falls in the completion cycle.
   - I_READDATA holds A5A5… one further cycle.
   - MEM_READ=0 in RELEASE.
2. Lone D_WRITE, D_ADDR=28'h00000FF, D_WRITEDATA=128'h1234…
   - MEM_WRITE=1, MEM_ADDR=0xFF, data passed through.
   - D_BUSYWAIT=0 only in the completion cycle.
   - I_BUSYWAIT stays 0 throughout.
3. I_READ and D_READ raised at the same negedge:
   - D is served first and I_BUSYWAIT stays 1.
   - I's strobe reaches memory exactly 2 cycles after D's completion.
   - I_READDATA equals I's block, not D's.
4. With MEM_ARB_RR_EN: D, then simultaneous I+D, gives grant order D, I, D. Without the macro, the order is D, D, I.
5. RESET pulsed while in GRANT_D with MEM_BUSYWAIT=1:
   - MEM_WRITE drops asynchronously.
   - state=IDLE and data_q=0.
   - After release, the held D request is re-granted.
6. Memory with zero wait (MEM_BUSYWAIT=0 in the first grant cycle): completion occurs in a single grant cycle, then RELEASE, then IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Optional round-robin tie-break is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 28;   // block address, word address bits [31:4]
    localparam int BLOCK_W_DEF = 128;  // one block = 4 words

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_I = 2'b01,
        ST_GRANT_D = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

    // Owner of a grant; also the encoding of the last-grant register.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Map a chosen owner to the grant state that serves it.
    function automatic state_t grant_state(input logic owner);
        return (owner == OWNER_D) ? ST_GRANT_D : ST_GRANT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational choice of the next bus owner from the two pending requests.
// MEM_ARB_RR_EN: on a tie, pick the requester that was not served last;
// otherwise the data cache always wins a tie.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic valid,
    output logic owner
);

`ifndef MEM_ARB_RR_EN
    // last_grant only matters for the round-robin tie-break.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the owner; a lone request is always granted to its requester.
    always_comb begin
        valid = i_req | d_req;
        owner = OWNER_D;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            owner = (last_grant == OWNER_D) ? OWNER_I : OWNER_D;
        end else if (i_req) begin
            owner = OWNER_I;
        end
`else
        if (i_req && !d_req) begin
            owner = OWNER_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide main memory between the instruction cache (refills)
// and the data cache (refills and write-backs). One block transaction at a
// time, non-preemptive, with a one-cycle release bubble after each grant.
// State updates on the falling clock edge to line up with the cache FSMs.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking instead of
// fixed data-over-instruction priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    // instruction cache
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDR,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    // data cache
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDR,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    // main memory
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    state_t             state_reg;
    state_t             state_next;
    logic [BLOCK_W-1:0] data_q;
    logic               last_grant;
    logic               pick_valid;
    logic               pick_owner;
    logic               d_req;
    logic               i_done;
    logic               d_done;

    // A write-back wins over a refill if both strobes are ever seen together.
    assign d_req  = D_READ | D_WRITE;

    // Completion: the cycle of a grant in which memory drops its busy flag.
    assign i_done = (state_reg == ST_GRANT_I) && !MEM_BUSYWAIT;
    assign d_done = (state_reg == ST_GRANT_D) && !MEM_BUSYWAIT;

`ifdef MEM_ARB_RR_EN
    logic last_grant_reg;

    // Remember who was granted most recently; starts out as the data cache.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            last_grant_reg <= OWNER_D;
        end else if (state_reg == ST_IDLE && pick_valid) begin
            last_grant_reg <= pick_owner;
        end
    end

    assign last_grant = last_grant_reg;
`else
    assign last_grant = OWNER_D;
`endif

    arb_pick u_pick (
        .i_req      (I_READ),
        .d_req      (d_req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

    // State register and read-data capture at the end of each completion.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            data_q    <= '0;
        end else begin
            state_reg <= state_next;
            if (i_done || d_done) begin
                data_q <= MEM_READDATA;
            end
        end
    end

    // Next-state: grant from IDLE, hold until completion, then one bubble.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = grant_state(pick_owner);
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (!MEM_BUSYWAIT) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Memory side: route the granted requester; everything is 0 otherwise.
    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDR      = '0;
        MEM_WRITEDATA = '0;
        case (state_reg)
            ST_GRANT_I: begin
                MEM_READ = I_READ;
                MEM_ADDR = I_ADDR;
            end
            ST_GRANT_D: begin
                MEM_WRITE     = D_WRITE;
                MEM_READ      = D_READ & ~D_WRITE;
                MEM_ADDR      = D_ADDR;
                MEM_WRITEDATA = D_WRITEDATA;
            end
            default: begin
                MEM_READ = 1'b0;
            end
        endcase
    end

    // Cache side: stall any pending requester except in its own completion;
    // read data bypasses the capture register during that completion.
    always_comb begin
        I_BUSYWAIT = I_READ & ~i_done;
        D_BUSYWAIT = d_req  & ~d_done;
        I_READDATA = i_done ? MEM_READDATA : data_q;
        D_READDATA = d_done ? MEM_READDATA : data_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small wait-state memory model.
module tb_mem_arbiter;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_READ, D_READ, D_WRITE;
    logic [27:0]   I_ADDR, D_ADDR;
    logic [127:0]  D_WRITEDATA;
    logic [127:0]  I_READDATA, D_READDATA;
    logic          I_BUSYWAIT, D_BUSYWAIT;
    logic          MEM_READ, MEM_WRITE;
    logic [27:0]   MEM_ADDR;
    logic [127:0]  MEM_WRITEDATA, MEM_READDATA;
    logic          MEM_BUSYWAIT;

    int checks = 0;
    int failures = 0;
    int mem_wait = 0;
    int mem_cnt;
    logic prev_strobe = 1'b0;
    logic [27:0] grant_log[$];

    localparam logic [127:0] A5_BLK = {16{8'hA5}};
    localparam logic [127:0] WB_BLK = 128'h123456789ABCDEF00FEDCBA987654321;

    mem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for mem_wait strobe cycles, then one completion cycle.
    always @(negedge CLK or posedge RESET) begin
        if (RESET) mem_cnt <= 0;
        else if (MEM_READ || MEM_WRITE) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_wait);
    assign MEM_READDATA = (MEM_ADDR == 28'h10) ? A5_BLK : {4{4'hD, MEM_ADDR}};

    // Log the address of every new grant seen by memory.
    always @(posedge CLK) begin
        if ((MEM_READ || MEM_WRITE) && !prev_strobe) grant_log.push_back(MEM_ADDR);
        prev_strobe <= MEM_READ | MEM_WRITE;
    end

    function automatic logic [127:0] blk(input logic [27:0] a);
        return {4{4'hD, a}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic sample();
        @(posedge CLK);
        #1;
    endtask

    // Act as both caches: drop each request in the cycle after its completion.
    task automatic serve(input string tag, input int max_cyc);
        bit i_pend, d_pend, i_hit, d_hit;
        int n;
        i_pend = I_READ;
        d_pend = D_READ | D_WRITE;
        n = 0;
        while ((i_pend || d_pend) && n < max_cyc) begin
            sample();
            i_hit = i_pend && !I_BUSYWAIT;
            d_hit = d_pend && !D_BUSYWAIT;
            next_cyc();
            if (i_hit) begin I_READ = 1'b0; i_pend = 1'b0; end
            if (d_hit) begin D_READ = 1'b0; D_WRITE = 1'b0; d_pend = 1'b0; end
            n++;
        end
        chk({tag, "_pending"}, {126'd0, i_pend, d_pend}, 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        I_READ = 0; D_READ = 0; D_WRITE = 0;
        I_ADDR = '0; D_ADDR = '0; D_WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        sample();
        chk("rst_mem_read", MEM_READ, 0);
        chk("rst_mem_write", MEM_WRITE, 0);
        chk("rst_i_busy", I_BUSYWAIT, 0);
        chk("rst_d_busy", D_BUSYWAIT, 0);
        chk("rst_i_rdata", I_READDATA, 0);
        next_cyc();
        RESET = 1'b0;

        // 1: lone instruction refill, 3 busy cycles
        mem_wait = 3;
        next_cyc(); I_READ = 1; I_ADDR = 28'h10;
        sample(); chk("t1_idle_busy", I_BUSYWAIT, 1); chk("t1_idle_noread", MEM_READ, 0);
        next_cyc();
        sample(); chk("t1_read", MEM_READ, 1); chk("t1_addr", MEM_ADDR, 28'h10);
        chk("t1_busy0", I_BUSYWAIT, 1); chk("t1_nowrite", MEM_WRITE, 0);
        next_cyc(); sample(); chk("t1_busy1", I_BUSYWAIT, 1);
        next_cyc(); sample(); chk("t1_busy2", I_BUSYWAIT, 1);
        next_cyc(); sample(); chk("t1_done_busy", I_BUSYWAIT, 0); chk("t1_done_data", I_READDATA, A5_BLK);
        next_cyc(); I_READ = 0;
        sample(); chk("t1_rel_read", MEM_READ, 0); chk("t1_hold_data", I_READDATA, A5_BLK);

        // 2: lone data write-back, 2 busy cycles
        mem_wait = 2;
        next_cyc(); D_WRITE = 1; D_ADDR = 28'hFF; D_WRITEDATA = WB_BLK;
        sample(); chk("t2_idle_busy", D_BUSYWAIT, 1); chk("t2_idle_nowrite", MEM_WRITE, 0);
        chk("t2_i_busy_a", I_BUSYWAIT, 0);
        next_cyc();
        sample(); chk("t2_write", MEM_WRITE, 1); chk("t2_noread", MEM_READ, 0);
        chk("t2_addr", MEM_ADDR, 28'hFF); chk("t2_wdata", MEM_WRITEDATA, WB_BLK);
        chk("t2_busy0", D_BUSYWAIT, 1); chk("t2_i_busy_b", I_BUSYWAIT, 0);
        next_cyc(); sample(); chk("t2_busy1", D_BUSYWAIT, 1);
        next_cyc(); sample(); chk("t2_done_busy", D_BUSYWAIT, 0); chk("t2_done_write", MEM_WRITE, 1);
        next_cyc(); D_WRITE = 0;
        sample(); chk("t2_rel_write", MEM_WRITE, 0); chk("t2_rel_wdata", MEM_WRITEDATA, 0);
        chk("t2_i_busy_c", I_BUSYWAIT, 0);

        // 3: simultaneous I and D refills, 1 busy cycle; D first
        mem_wait = 1;
        next_cyc(); I_READ = 1; I_ADDR = 28'h20; D_READ = 1; D_ADDR = 28'h30;
        sample(); chk("t3_idle_ib", I_BUSYWAIT, 1); chk("t3_idle_db", D_BUSYWAIT, 1);
        next_cyc();
        sample(); chk("t3_d_read", MEM_READ, 1); chk("t3_d_addr", MEM_ADDR, 28'h30);
        chk("t3_ib_a", I_BUSYWAIT, 1);
        next_cyc();
        sample(); chk("t3_d_done", D_BUSYWAIT, 0); chk("t3_d_data", D_READDATA, blk(28'h30));
        chk("t3_ib_b", I_BUSYWAIT, 1);
        next_cyc(); D_READ = 0;
        sample(); chk("t3_rel_read", MEM_READ, 0); chk("t3_ib_c", I_BUSYWAIT, 1);
        chk("t3_d_hold", D_READDATA, blk(28'h30));
        next_cyc();
        sample(); chk("t3_idle_read", MEM_READ, 0); chk("t3_ib_d", I_BUSYWAIT, 1);
        next_cyc();
        sample(); chk("t3_i_read", MEM_READ, 1); chk("t3_i_addr", MEM_ADDR, 28'h20);
        next_cyc();
        sample(); chk("t3_i_done", I_BUSYWAIT, 0); chk("t3_i_data", I_READDATA, blk(28'h20));
        next_cyc(); I_READ = 0;
        sample(); chk("t3_i_hold", I_READDATA, blk(28'h20));

        // 4: D alone, then I and D together; grant order depends on build
        mem_wait = 0;
        grant_log.delete();
        next_cyc(); D_READ = 1; D_ADDR = 28'h40;
        serve("t4a", 20);
        next_cyc(); I_READ = 1; I_ADDR = 28'h50; D_READ = 1; D_ADDR = 28'h60;
        serve("t4b", 40);
        chk("t4_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("t4_g0", grant_log[0], 28'h40);
`ifdef MEM_ARB_RR_EN
            chk("t4_g1", grant_log[1], 28'h50);
            chk("t4_g2", grant_log[2], 28'h60);
`else
            chk("t4_g1", grant_log[1], 28'h60);
            chk("t4_g2", grant_log[2], 28'h50);
`endif
        end

        // 5: reset in the middle of a data write-back grant
        mem_wait = 5;
        next_cyc(); D_WRITE = 1; D_ADDR = 28'h70; D_WRITEDATA = WB_BLK;
        sample(); chk("t5_idle_db", D_BUSYWAIT, 1);
        next_cyc();
        sample(); chk("t5_write", MEM_WRITE, 1); chk("t5_mem_busy", MEM_BUSYWAIT, 1);
        RESET = 1; #1;
        chk("t5_async_write", MEM_WRITE, 0); chk("t5_async_addr", MEM_ADDR, 0);
        chk("t5_rst_db", D_BUSYWAIT, 1); chk("t5_rst_dq_d", D_READDATA, 0);
        chk("t5_rst_dq_i", I_READDATA, 0);
        mem_wait = 1;
        next_cyc(); RESET = 0;
        sample(); chk("t5_idle_write", MEM_WRITE, 0);
        next_cyc();
        sample(); chk("t5_regrant", MEM_WRITE, 1); chk("t5_regrant_addr", MEM_ADDR, 28'h70);
        serve("t5", 20);

        // 6: zero-wait memory, single-cycle grant then RELEASE then IDLE
        mem_wait = 0;
        next_cyc(); I_READ = 1; I_ADDR = 28'h80;
        sample(); chk("t6_idle_read", MEM_READ, 0); chk("t6_idle_ib", I_BUSYWAIT, 1);
        next_cyc();
        sample(); chk("t6_read", MEM_READ, 1); chk("t6_addr", MEM_ADDR, 28'h80);
        chk("t6_done", I_BUSYWAIT, 0); chk("t6_data", I_READDATA, blk(28'h80));
        next_cyc(); I_READ = 0;
        sample(); chk("t6_rel_read", MEM_READ, 0); chk("t6_hold", I_READDATA, blk(28'h80));
        next_cyc(); D_READ = 1; D_ADDR = 28'h90;
        sample(); chk("t6_idle2_read", MEM_READ, 0); chk("t6_idle2_db", D_BUSYWAIT, 1);
        next_cyc();
        sample(); chk("t6_d_read", MEM_READ, 1); chk("t6_d_addr", MEM_ADDR, 28'h90);
        chk("t6_d_done", D_BUSYWAIT, 0); chk("t6_d_data", D_READDATA, blk(28'h90));
        next_cyc(); D_READ = 0;
        sample(); chk("t6_d_rel", MEM_READ, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
